// File: rtl/vga_scope_scan_ctrl.sv
// Purpose: 640x480@60 VGA scan-out with trace/graticule render; single-port sample RAM arbiter (display reads win, writer fills free cycles).
// Latency: counter-to-pin 2 cycles for sync and colour; write grant/ack is combinational in the issuing cycle.
// Backpressure: wr_req waits unbounded for a free cycle; SCOPE_VBLANK_ONLY_WR_EN restricts grants to vertical blanking lines.
module vga_scope_scan_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8
) (
    input  logic              clk_25MHz,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_start,
    output logic              Hsynq,
    output logic              Vsynq,
    output logic [3:0]        Red,
    output logic [3:0]        Green,
    output logic [3:0]        Blue
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CW    = VW + DATA_W;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_START    = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_END      = HW'(H_TOT - H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_START    = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_END      = VW'(V_TOT - V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] Y_LAST     = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] GRID_X     = HW'(64);
    localparam logic [VW-1:0] GRID_Y     = VW'(60);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_act, v_act, act0, wr_permit, grant;
    logic [HW-1:0] x0;
    logic [VW-1:0] y0;

    logic          act1, hs1, vs1;
    logic [HW-1:0] x1;
    logic [VW-1:0] y1;

    logic [CW-1:0] trace_tgt;
    logic          trace_hit, grid_hit;
    logic [3:0]    red_n, green_n, blue_n;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_act = (h_cnt >= H_START) && (h_cnt < H_END);
        v_act = (v_cnt >= V_START) && (v_cnt < V_END);
        act0  = h_act && v_act;
        x0    = h_cnt - H_START;
        y0    = v_cnt - V_START;
    end

`ifdef SCOPE_VBLANK_ONLY_WR_EN
    assign wr_permit = !v_act;
`else
    assign wr_permit = !act0;
`endif

    // rst_n gates the port combinationally so a reset kills an in-flight write at once
    assign grant       = rst_n && wr_permit && wr_req;
    assign wr_ack      = grant;
    assign frame_start = rst_n && (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n && act0) begin
            mem_en   = 1'b1;
            mem_addr = ADDR_W'(x0);
        end else if (grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            act1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            x1   <= '0;
            y1   <= '0;
        end else begin
            act1 <= act0;
            hs1  <= (h_cnt < H_SYNC_END);
            vs1  <= (v_cnt < V_SYNC_END);
            x1   <= x0;
            y1   <= y0;
        end
    end

    // Sample s sits on rows where (479-y)>>1 == s, so the top of the screen shows the largest value
    always_comb begin
        trace_tgt = CW'((Y_LAST - y1) >> 1);
        trace_hit = (CW'(mem_rdata) == trace_tgt);
        grid_hit  = ((x1 % GRID_X) == '0) || ((y1 % GRID_Y) == '0);
        red_n     = 4'h0;
        green_n   = 4'h0;
        blue_n    = 4'h0;
        if (act1) begin
            if (trace_hit) begin
                green_n = 4'hF;
            end else if (grid_hit) begin
                red_n   = 4'h4;
                green_n = 4'h4;
                blue_n  = 4'h4;
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            Hsynq <= 1'b0;
            Vsynq <= 1'b0;
            Red   <= 4'h0;
            Green <= 4'h0;
            Blue  <= 4'h0;
        end else begin
            Hsynq <= hs1;
            Vsynq <= vs1;
            Red   <= red_n;
            Green <= green_n;
            Blue  <= blue_n;
        end
    end
endmodule

// File: tb/tb_vga_scope_scan_ctrl.sv
// Directed bench for vga_scope_scan_ctrl: sync timing, pixel render, write arbitration and async reset.
module tb_vga_scope_scan_ctrl;
    logic       clk_25MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       wr_req    = 1'b0;
    logic [9:0] wr_addr   = '0;
    logic [7:0] wr_data   = '0;
    logic       wr_ack, mem_en, mem_we, frame_start, Hsynq, Vsynq;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [3:0] Red, Green, Blue;

    logic [7:0] ram [0:1023];
    int cyc  = 0;
    int vecs = 0;
    int errs = 0;

    vga_scope_scan_ctrl dut (
        .clk_25MHz(clk_25MHz), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .frame_start(frame_start),
        .Hsynq(Hsynq), .Vsynq(Vsynq), .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // cyc == k means stage-0 counters are at frame position k
    always @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk_25MHz) begin
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    function automatic int idx(input int v, input int h);
        return v * 800 + h;
    endfunction

    function automatic int pix(input int x, input int y);
        return idx(y + 35, x + 144) + 2;
    endfunction

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 100000) begin
            @(negedge clk_25MHz);
            guard++;
        end
        #1;
        vecs++;
        if (cyc != n) begin
            errs++;
            $display("FAIL wait_cyc: at cycle %0d, wanted cycle %0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        wr_addr = 10'd7; wr_data = 8'h22; wr_req = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        #1;
        vecs++;
        if ({wr_ack, mem_en, mem_we, frame_start, Hsynq, Vsynq, Red, Green, Blue} !== '0) begin
            errs++;
            $display("FAIL reset_hold: ack=%b en=%b we=%b fs=%b hs=%b vs=%b rgb=%h, required all 0",
                     wr_ack, mem_en, mem_we, frame_start, Hsynq, Vsynq, {Red, Green, Blue});
        end
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (frame_start !== 1'b1 || wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd7 || mem_wdata !== 8'h22) begin
            errs++;
            $display("FAIL reset_release: fs=%b ack=%b we=%b addr=%0d wdata=%h, required 1 1 1 7 22",
                     frame_start, wr_ack, mem_we, mem_addr, mem_wdata);
        end
        wait_cyc(1);
        wr_req = 1'b0;
        #1;
        vecs++;
        if (frame_start !== 1'b0 || wr_ack !== 1'b0) begin
            errs++;
            $display("FAIL reset_cycle1: fs=%b ack=%b, required 0 0", frame_start, wr_ack);
        end
    endtask

    task automatic test_sync();
        int hs = 0, fs = 0, nz = 0;
        for (int n = 1; n <= 1700; n++) begin
            wait_cyc(n);
            if (n >= 2 && n <= 801 && Hsynq === 1'b1) hs++;
            if (frame_start !== 1'b0) fs++;
            if ({Red, Green, Blue} !== 12'h000) nz++;
            if (n == 1 || n == 2 || n == 97 || n == 98) begin
                vecs++;
                if (Hsynq !== ((n == 2 || n == 97) ? 1'b1 : 1'b0)) begin
                    errs++;
                    $display("FAIL hsync_edge: cycle %0d Hsynq=%b", n, Hsynq);
                end
            end
            if (n == 2 || n == 1601 || n == 1602) begin
                vecs++;
                if (Vsynq !== ((n == 1602) ? 1'b0 : 1'b1)) begin
                    errs++;
                    $display("FAIL vsync_edge: cycle %0d Vsynq=%b", n, Vsynq);
                end
            end
        end
        vecs++;
        if (hs != 96 || fs != 0 || nz != 0) begin
            errs++;
            $display("FAIL sync_line0: hs_high=%0d fs_pulses=%0d rgb_nonzero=%0d, required 96 0 0", hs, fs, nz);
        end
    endtask

    task automatic test_blank_line();
        int hs = 0, nz = 0;
        for (int h = 0; h < 800; h++) begin
            wait_cyc(idx(10, h) + 2);
            if (Hsynq === 1'b1) hs++;
            if ({Red, Green, Blue} !== 12'h000) nz++;
        end
        vecs++;
        if (hs != 96 || nz != 0 || Vsynq !== 1'b0) begin
            errs++;
            $display("FAIL blank_line: hs_high=%0d rgb_nonzero=%0d vs=%b, required 96 0 0", hs, nz, Vsynq);
        end
    endtask

    task automatic test_pixels_top();
        int         tx [13] = '{-1, 0, 1, 100, 200, 639, 640, 0, 65, 100, 300, 576, 639};
        int         ty [13] = '{ 0, 0, 0,   0,   0,   0,   0, 1,  1,   1,   1,   1,   1};
        logic [11:0] te [13] = '{12'h000, 12'h444, 12'h444, 12'h0F0, 12'h444, 12'h444, 12'h000,
                                 12'h444, 12'h000, 12'h0F0, 12'h000, 12'h444, 12'h000};
        for (int i = 0; i < 13; i++) begin
            wait_cyc(pix(tx[i], ty[i]));
            vecs++;
            if ({Red, Green, Blue} !== te[i]) begin
                errs++;
                $display("FAIL pixel(%0d,%0d): rgb=%h, required %h", tx[i], ty[i], {Red, Green, Blue}, te[i]);
            end
        end
    endtask

    task automatic test_write_active();
        int base = idx(37, 0);
        int bad = 0, acks = 0;
        wait_cyc(base + 200);
        wr_addr = 10'd5; wr_data = 8'h10; wr_req = 1'b1;
        #1;
        vecs++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 10'd56) begin
            errs++;
            $display("FAIL wr_active_read: ack=%b we=%b en=%b addr=%0d, required 0 0 1 56", wr_ack, mem_we, mem_en, mem_addr);
        end
        for (int h = 201; h < 784; h++) begin
            wait_cyc(base + h);
            if (wr_ack !== 1'b0 || mem_we !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL wr_no_grant_active: %0d granted cycles, required 0", bad);
        end
        wait_cyc(base + 784);
        vecs++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 8'h10) begin
            errs++;
            $display("FAIL wr_first_blank: ack=%b we=%b en=%b addr=%0d wdata=%h, required 1 1 1 5 10",
                     wr_ack, mem_we, mem_en, mem_addr, mem_wdata);
        end
        wait_cyc(base + 785);
        wr_req = 1'b0;
        #1;
        vecs++;
        if (wr_ack !== 1'b0 || mem_en !== 1'b0) begin
            errs++;
            $display("FAIL wr_idle: ack=%b en=%b, required 0 0", wr_ack, mem_en);
        end
        wait_cyc(base + 786);
        wr_addr = 10'd700; wr_data = 8'hAB; wr_req = 1'b1;
        #1;
        for (int h = 786; h < 789; h++) begin
            if (h > 786) wait_cyc(base + h);
            if (wr_ack === 1'b1 && mem_we === 1'b1 && mem_addr === 10'd700 && mem_wdata === 8'hAB) acks++;
        end
        vecs++;
        if (acks != 3) begin
            errs++;
            $display("FAIL wr_back_to_back: %0d acks to addr 700, required 3", acks);
        end
        wait_cyc(base + 789);
        wr_req = 1'b0;
        #1;
    endtask

    task automatic test_drop_request();
        int base = idx(38, 0);
        int acks = 0;
        for (int h = 300; h < 944; h++) begin
            wait_cyc(base + h);
            if (h == 300) begin wr_addr = 10'd9; wr_req = 1'b1; #1; end
            if (h == 500) begin wr_req = 1'b0; #1; end
            if (wr_ack !== 1'b0) acks++;
            if (h == 784) begin
                vecs++;
                if (wr_ack !== 1'b0 || mem_en !== 1'b0) begin
                    errs++;
                    $display("FAIL drop_at_blank: ack=%b en=%b, required 0 0", wr_ack, mem_en);
                end
            end
        end
        vecs++;
        if (acks != 0) begin
            errs++;
            $display("FAIL drop_no_ack: %0d acks, required 0", acks);
        end
    endtask

    task automatic test_grid_trace();
        int         tx [6] = '{64, 64, 65, 0, 64, 66};
        int         ty [6] = '{59, 60, 60, 60, 61, 61};
        logic [11:0] te [6] = '{12'h444, 12'h0F0, 12'h444, 12'h444, 12'h0F0, 12'h000};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) continue;
            wait_cyc(pix(tx[i], ty[i]));
            vecs++;
            if ({Red, Green, Blue} !== te[i]) begin
                errs++;
                $display("FAIL grid_pixel(%0d,%0d): rgb=%h, required %h", tx[i], ty[i], {Red, Green, Blue}, te[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_cyc(pix(128, 62));
        wr_addr = 10'd3; wr_data = 8'h55; wr_req = 1'b1;
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h444 || mem_en !== 1'b1 || wr_ack !== 1'b0 || mem_addr !== 10'd130) begin
            errs++;
            $display("FAIL pre_reset: rgb=%h en=%b ack=%b addr=%0d, required 444 1 0 130",
                     {Red, Green, Blue}, mem_en, wr_ack, mem_addr);
        end
        #5 rst_n = 1'b0;
        #1;
        vecs++;
        if ({wr_ack, mem_en, mem_we, frame_start, Hsynq, Vsynq, Red, Green, Blue} !== '0 || mem_addr !== 10'd0) begin
            errs++;
            $display("FAIL async_reset: ack=%b en=%b we=%b fs=%b rgb=%h addr=%0d, required all 0",
                     wr_ack, mem_en, mem_we, frame_start, {Red, Green, Blue}, mem_addr);
        end
        repeat (2) @(negedge clk_25MHz);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (frame_start !== 1'b1 || wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd3 || mem_wdata !== 8'h55 || Hsynq !== 1'b0) begin
            errs++;
            $display("FAIL regrant_after_reset: fs=%b ack=%b we=%b addr=%0d wdata=%h hs=%b, required 1 1 1 3 55 0",
                     frame_start, wr_ack, mem_we, mem_addr, mem_wdata, Hsynq);
        end
        wait_cyc(1);
        vecs++;
        if (wr_ack !== 1'b1 || frame_start !== 1'b0) begin
            errs++;
            $display("FAIL held_regrant: ack=%b fs=%b, required 1 0", wr_ack, frame_start);
        end
        wait_cyc(2);
        wr_req = 1'b0;
        #1;
        vecs++;
        if (Hsynq !== 1'b1 || Vsynq !== 1'b1 || wr_ack !== 1'b0) begin
            errs++;
            $display("FAIL sync_after_reset: hs=%b vs=%b ack=%b, required 1 1 0", Hsynq, Vsynq, wr_ack);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'hFF;
        ram[100] = 8'hEF;
        ram[200] = 8'hF0;
        ram[300] = 8'hF0;
        ram[64]  = 8'hD1;
        test_reset();
        test_sync();
        test_blank_line();
        test_pixels_top();
        test_write_active();
        test_drop_request();
        test_grid_trace();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
